// File: rtl/if_inst_resp_buffer_if.sv
// Bundle of the IF-stage response-side signals between the instruction SRAM
// response port, preIF, IF/ID handshake and the response buffer.
//
// Handshake semantics: a request is accepted in a cycle where both
// inst_sram_req_i and inst_sram_addr_ok_i are high; a response is delivered
// in any cycle where inst_sram_data_ok_i is high (no ready, responses are in
// order); IF hands its packet to ID in a cycle where if_valid_i and
// id_allowin_i are both high.
interface if_inst_resp_buffer_if #(
    parameter int CNT_W = 2
);
    logic             inst_sram_req_i;
    logic             inst_sram_addr_ok_i;
    logic             inst_sram_data_ok_i;
    logic [63:0]      inst_sram_rdata_i;
    logic             excep_flush_i;
    logic             if_valid_i;
    logic             id_allowin_i;
    logic             data_ok_to_if_o;
    logic [63:0]      ram_inst_o;
    logic             inst_rdata_buffer_ok_o;
    logic [63:0]      inst_rdata_buffer_rdata_o;
    logic             req_block_o;
    logic [CNT_W-1:0] outstanding_cnt_o;
    logic             overflow_o;

    // Side seen by the response buffer itself
    modport slave (
        input  inst_sram_req_i, inst_sram_addr_ok_i, inst_sram_data_ok_i,
               inst_sram_rdata_i, excep_flush_i, if_valid_i, id_allowin_i,
        output data_ok_to_if_o, ram_inst_o, inst_rdata_buffer_ok_o,
               inst_rdata_buffer_rdata_o, req_block_o, outstanding_cnt_o,
               overflow_o
    );

    // Side seen by the surrounding pipeline / environment
    modport master (
        output inst_sram_req_i, inst_sram_addr_ok_i, inst_sram_data_ok_i,
               inst_sram_rdata_i, excep_flush_i, if_valid_i, id_allowin_i,
        input  data_ok_to_if_o, ram_inst_o, inst_rdata_buffer_ok_o,
               inst_rdata_buffer_rdata_o, req_block_o, outstanding_cnt_o,
               overflow_o
    );
endinterface

// File: rtl/if_inst_resp_buffer.sv
// IF-stage instruction response buffer: counts outstanding SRAM requests,
// discards responses to requests issued before an exception flush, and
// holds one 64-bit fetch packet while IF is stalled by ID.
module if_inst_resp_buffer #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 2
) (
    input logic                  clk,
    input logic                  rst,
    if_inst_resp_buffer_if.slave bus
);
    logic             acc;
    logic             rsp;
    logic             pass;
    logic             capture;
    logic             release_buf;
    logic             rsp_underflow;
    logic             buf_overrun;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] cancel_cnt;
    logic [CNT_W+1:0] flush_sum;
    logic [CNT_W+1:0] flush_total;
    logic             buf_valid;
    logic [63:0]      buf_data;
    logic             overflow;

    // Event decode and response filtering from current inputs and registered state
    always_comb begin
        acc           = bus.inst_sram_req_i & bus.inst_sram_addr_ok_i;
        rsp           = bus.inst_sram_data_ok_i;
        pass          = rsp & (cancel_cnt == '0) & ~bus.excep_flush_i;
        release_buf   = buf_valid & bus.if_valid_i & bus.id_allowin_i;
        capture       = pass & bus.if_valid_i & ~bus.id_allowin_i & ~buf_valid;
        rsp_underflow = rsp & ~acc & (out_cnt == '0);
        buf_overrun   = pass & buf_valid & ~release_buf;
    end

    // Stale-response total on a flush: everything already owed plus everything
    // in flight (including an acceptance this cycle), minus a response consumed now
    always_comb begin
        flush_sum   = {2'b00, cancel_cnt} + {2'b00, out_cnt} + (CNT_W+2)'(acc);
        flush_total = flush_sum;
        if (rsp) begin
            flush_total = (flush_sum == '0) ? '0 : flush_sum - (CNT_W+2)'(1);
        end
        if (flush_total > (CNT_W+2)'(MAX_OUTSTANDING)) begin
            flush_total = (CNT_W+2)'(MAX_OUTSTANDING);
        end
    end

    // Outstanding-request counter; a response with nothing outstanding holds at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (acc & ~rsp) begin
            out_cnt <= out_cnt + CNT_W'(1);
        end else if (rsp & ~acc & (out_cnt != '0)) begin
            out_cnt <= out_cnt - CNT_W'(1);
        end
    end

    // Count of in-flight responses that must be swallowed after a flush
    always_ff @(posedge clk) begin
        if (rst) begin
            cancel_cnt <= '0;
        end else if (bus.excep_flush_i) begin
            cancel_cnt <= flush_total[CNT_W-1:0];
        end else if (rsp & (cancel_cnt != '0)) begin
            cancel_cnt <= cancel_cnt - CNT_W'(1);
        end
    end

    // Replay buffer: flush wins, then IF consuming the packet, then a new capture
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else if (bus.excep_flush_i) begin
            buf_valid <= 1'b0;
        end else if (release_buf) begin
            buf_valid <= 1'b0;
        end else if (capture) begin
            buf_valid <= 1'b1;
            buf_data  <= bus.inst_sram_rdata_i;
        end
    end

    // Sticky protocol-error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (rsp_underflow | buf_overrun) begin
            overflow <= 1'b1;
        end
    end

    // Output drive; request blocking depends on registered state only
    always_comb begin
        bus.data_ok_to_if_o           = pass;
        bus.ram_inst_o                = bus.inst_sram_rdata_i;
        bus.inst_rdata_buffer_ok_o    = buf_valid;
        bus.inst_rdata_buffer_rdata_o = buf_data;
        bus.req_block_o               = (out_cnt == CNT_W'(MAX_OUTSTANDING)) | buf_valid;
        bus.outstanding_cnt_o         = out_cnt;
        bus.overflow_o                = overflow;
    end
endmodule

// File: tb/tb_if_inst_resp_buffer.sv
// Bench for if_inst_resp_buffer: directed scenarios with literal checks,
// then randomized legal traffic, all compared every cycle against a model.
module tb_if_inst_resp_buffer;
  localparam int MAX_OUT = 2;
  localparam int CW      = 2;

  logic clk;
  logic rst;
  logic req, aok, dok, flush, ifv, ida;
  logic [63:0] rdata;

  int n_total;
  int n_bad;
  bit chk_en;

  // behavioural model state
  int          m_out;
  int          m_cancel;
  bit          m_bv;
  logic [63:0] m_bd;
  bit          m_ovf;

  if_inst_resp_buffer_if #(.CNT_W(CW)) bus ();

  assign bus.inst_sram_req_i     = req;
  assign bus.inst_sram_addr_ok_i = aok;
  assign bus.inst_sram_data_ok_i = dok;
  assign bus.inst_sram_rdata_i   = rdata;
  assign bus.excep_flush_i       = flush;
  assign bus.if_valid_i          = ifv;
  assign bus.id_allowin_i        = ida;

  if_inst_resp_buffer #(.MAX_OUTSTANDING(MAX_OUT), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // advance the model across one clock edge using the inputs currently applied
  task automatic model_step();
    bit acc, rsp, pass, rel;
    int t;
    acc  = req & aok;
    rsp  = dok;
    pass = rsp && (m_cancel == 0) && !flush;
    rel  = m_bv && ifv && ida;
    if (rst) begin
      m_out = 0; m_cancel = 0; m_bv = 0; m_bd = '0; m_ovf = 0;
      return;
    end
    if (pass && m_bv && !rel) m_ovf = 1;
    if (flush) begin
      t = m_cancel + m_out + int'(acc) - int'(rsp);
      if (t < 0) t = 0;
      if (t > MAX_OUT) t = MAX_OUT;
      m_cancel = t;
    end else if (rsp && m_cancel > 0) begin
      m_cancel = m_cancel - 1;
    end
    if (acc && !rsp) m_out = m_out + 1;
    else if (rsp && !acc) begin
      if (m_out == 0) m_ovf = 1;
      else m_out = m_out - 1;
    end
    if (flush || rel) m_bv = 0;
    else if (pass && ifv && !ida && !m_bv) begin
      m_bv = 1;
      m_bd = rdata;
    end
  endtask

  // compare process: every cycle, outputs vs model, then step the model
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (chk_en) begin
        chk("data_ok_to_if", 64'(bus.data_ok_to_if_o), 64'(dok && m_cancel == 0 && !flush));
        chk("ram_inst", bus.ram_inst_o, rdata);
        chk("buf_ok", 64'(bus.inst_rdata_buffer_ok_o), 64'(m_bv));
        chk("buf_rdata", bus.inst_rdata_buffer_rdata_o, m_bd);
        chk("req_block", 64'(bus.req_block_o), 64'((m_out == MAX_OUT) || m_bv));
        chk("out_cnt", 64'(bus.outstanding_cnt_o), 64'(m_out));
        chk("overflow", 64'(bus.overflow_o), 64'(m_ovf));
      end
      model_step();
    end
  end

  // driver tasks
  task automatic drive(input logic r, input logic a, input logic d, input logic [63:0] rd,
                       input logic f, input logic iv, input logic ia);
    @(negedge clk);
    req = r; aok = a; dok = d; rdata = rd; flush = f; ifv = iv; ida = ia;
  endtask

  task automatic idle();
    drive(0, 0, 0, 64'h0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 0; aok = 0; dok = 0; rdata = '0; flush = 0; ifv = 0; ida = 1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_total = 0; n_bad = 0; chk_en = 0;
    m_out = 0; m_cancel = 0; m_bv = 0; m_bd = '0; m_ovf = 0;
    rst = 1'b1; req = 0; aok = 0; dok = 0; rdata = '0; flush = 0; ifv = 0; ida = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1;
    #1;
    chk("reset_buf_ok", 64'(bus.inst_rdata_buffer_ok_o), 64'd0);
    chk("reset_out_cnt", 64'(bus.outstanding_cnt_o), 64'd0);
    chk("reset_req_block", 64'(bus.req_block_o), 64'd0);

    // 1: normal passthrough
    drive(1, 1, 0, 64'h0, 0, 1, 1); #1 chk("t1_out0", 64'(bus.outstanding_cnt_o), 64'd0);
    drive(0, 0, 0, 64'h0, 0, 1, 1); #1 chk("t1_out1", 64'(bus.outstanding_cnt_o), 64'd1);
    drive(0, 0, 1, 64'h11112222_33334444, 0, 1, 1); #1;
    chk("t1_dok", 64'(bus.data_ok_to_if_o), 64'd1);
    chk("t1_ram", bus.ram_inst_o, 64'h11112222_33334444);
    idle(); #1;
    chk("t1_out_back", 64'(bus.outstanding_cnt_o), 64'd0);
    chk("t1_nobuf", 64'(bus.inst_rdata_buffer_ok_o), 64'd0);

    // 2: stall capture and replay
    drive(1, 1, 0, 64'h0, 0, 1, 1);
    drive(0, 0, 1, 64'hAAAA5555_DEADBEEF, 0, 1, 0); #1 chk("t2_dok", 64'(bus.data_ok_to_if_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 64'h0, 0, 1, 0); #1;
      chk("t2_buf_ok", 64'(bus.inst_rdata_buffer_ok_o), 64'd1);
      chk("t2_buf_data", bus.inst_rdata_buffer_rdata_o, 64'hAAAA5555_DEADBEEF);
      chk("t2_block", 64'(bus.req_block_o), 64'd1);
    end
    drive(0, 0, 0, 64'h0, 0, 1, 1); #1 chk("t2_buf_ok_last", 64'(bus.inst_rdata_buffer_ok_o), 64'd1);
    idle(); #1;
    chk("t2_buf_gone", 64'(bus.inst_rdata_buffer_ok_o), 64'd0);
    chk("t2_unblock", 64'(bus.req_block_o), 64'd0);

    // 3: flush with two outstanding
    drive(1, 1, 0, 64'h0, 0, 0, 1);
    drive(1, 1, 0, 64'h0, 0, 0, 1);
    drive(0, 0, 0, 64'h0, 1, 0, 1); #1;
    chk("t3_out2", 64'(bus.outstanding_cnt_o), 64'd2);
    chk("t3_block", 64'(bus.req_block_o), 64'd1);
    idle();
    drive(0, 0, 1, 64'h1, 0, 1, 1); #1 chk("t3_stale1", 64'(bus.data_ok_to_if_o), 64'd0);
    drive(0, 0, 1, 64'h2, 0, 1, 1); #1 chk("t3_stale2", 64'(bus.data_ok_to_if_o), 64'd0);
    drive(1, 1, 0, 64'h0, 0, 1, 1); #1 chk("t3_out0", 64'(bus.outstanding_cnt_o), 64'd0);
    drive(0, 0, 1, 64'h3, 0, 1, 1); #1 chk("t3_fresh", 64'(bus.data_ok_to_if_o), 64'd1);
    idle();

    // 4: flush, accept and respond in one cycle
    drive(1, 1, 0, 64'h0, 0, 1, 1);
    drive(1, 1, 1, 64'h4, 1, 1, 1); #1;
    chk("t4_dok_flush", 64'(bus.data_ok_to_if_o), 64'd0);
    chk("t4_out_pre", 64'(bus.outstanding_cnt_o), 64'd1);
    idle(); #1 chk("t4_out_post", 64'(bus.outstanding_cnt_o), 64'd1);
    drive(0, 0, 1, 64'h5, 0, 1, 1); #1 chk("t4_stale", 64'(bus.data_ok_to_if_o), 64'd0);
    idle(); #1 chk("t4_out0", 64'(bus.outstanding_cnt_o), 64'd0);
    drive(1, 1, 0, 64'h0, 0, 1, 1);
    drive(0, 0, 1, 64'h6, 0, 1, 1); #1 chk("t4_fresh", 64'(bus.data_ok_to_if_o), 64'd1);
    idle();

    // 5: flush while buffered, then reset mid-operation
    drive(1, 1, 0, 64'h0, 0, 1, 1);
    drive(0, 0, 1, 64'hCAFE0000_0000CAFE, 0, 1, 0);
    drive(0, 0, 0, 64'h0, 1, 1, 0); #1 chk("t5_buf_before", 64'(bus.inst_rdata_buffer_ok_o), 64'd1);
    idle(); #1 chk("t5_buf_flushed", 64'(bus.inst_rdata_buffer_ok_o), 64'd0);
    drive(1, 1, 0, 64'h0, 0, 0, 1);
    drive(1, 1, 0, 64'h0, 0, 0, 1);
    idle(); #1 chk("t5_out2", 64'(bus.outstanding_cnt_o), 64'd2);
    @(negedge clk);
    rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    #1;
    chk("t5_rst_dok", 64'(bus.data_ok_to_if_o), 64'd0);
    chk("t5_rst_bufok", 64'(bus.inst_rdata_buffer_ok_o), 64'd0);
    chk("t5_rst_bufdata", bus.inst_rdata_buffer_rdata_o, 64'd0);
    chk("t5_rst_block", 64'(bus.req_block_o), 64'd0);
    chk("t5_rst_out", 64'(bus.outstanding_cnt_o), 64'd0);
    chk("t5_rst_ovf", 64'(bus.overflow_o), 64'd0);

    // 6: buffer overrun sets the sticky flag and keeps the held packet
    drive(1, 1, 0, 64'h0, 0, 1, 1);
    drive(1, 1, 0, 64'h0, 0, 1, 1);
    drive(0, 0, 1, 64'h01234567_89ABCDEF, 0, 1, 0);
    drive(0, 0, 1, 64'hFEDCBA98_76543210, 0, 1, 0);
    idle(); #1;
    chk("t6_ovf", 64'(bus.overflow_o), 64'd1);
    chk("t6_data_kept", bus.inst_rdata_buffer_rdata_o, 64'h01234567_89ABCDEF);
    repeat (3) idle();
    #1 chk("t6_ovf_sticky", 64'(bus.overflow_o), 64'd1);
    do_reset();

    // randomized legal traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 499) begin
        do_reset();
      end else begin
        @(negedge clk);
        req   = ((m_out < MAX_OUT) && !m_bv) ? logic'($urandom_range(0, 1)) : 1'b0;
        aok   = logic'($urandom_range(0, 3) != 0);
        dok   = (m_out > 0) ? logic'($urandom_range(0, 2) == 0) : 1'b0;
        rdata = {$urandom, $urandom};
        flush = logic'($urandom_range(0, 15) == 0);
        ifv   = logic'($urandom_range(0, 3) != 0);
        ida   = logic'($urandom_range(0, 3) != 0);
      end
    end
    idle();
    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
